// File: rtl/nano_dsi_sched.sv
// nano_dsi_sched: round-robin HS data-lane scheduler for a command and a video requester,
// bringing the HS clock lane up before the first packet and releasing it after an idle timeout.
module nano_dsi_sched #(
  parameter int GAP     = 2,
  parameter int IDLE_TO = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       r0_valid,
  input  logic [7:0] r0_data,
  input  logic       r0_last,
  output logic       r0_ack,
  input  logic       r1_valid,
  input  logic [7:0] r1_data,
  input  logic       r1_last,
  output logic       r1_ack,
  output logic       hs_clk_req,
  input  logic       hs_clk_rdy,
  output logic       hs_start,
  output logic [7:0] hs_data,
  output logic       hs_last,
  input  logic       hs_ack,
  output logic       busy,
  output logic       err
);
  typedef enum logic [2:0] {S_OFF, S_CLK_UP, S_ARB, S_PKT, S_GAP, S_HOLD, S_CLK_DOWN} state_t;
  localparam logic [7:0] GAP_LD  = 8'(GAP - 1);
  localparam logic [7:0] IDLE_LD = 8'(IDLE_TO - 1);
  state_t     r_state, w_next;
  logic       r_g, r_start, r_err;
  logic       w_g, w_start, w_err;
  logic [7:0] r_cnt, w_cnt;
  logic       w_any, w_pick, w_in_pkt, w_gv, w_gl;
  logic [7:0] w_gd;
  assign w_any    = r0_valid | r1_valid;
  // r_g holds the last grant; it resets to r1 so r0 wins the first tie
  assign w_pick   = (r0_valid & r1_valid) ? ~r_g : r1_valid;
  assign w_in_pkt = r_state == S_PKT;
  assign w_gv     = r_g ? r1_valid : r0_valid;
  assign w_gl     = r_g ? r1_last : r0_last;
  assign w_gd     = r_g ? r1_data : r0_data;
  assign hs_data    = (w_in_pkt & w_gv) ? w_gd : 8'h00;
  assign hs_last    = w_in_pkt & w_gv & w_gl;
  assign hs_start   = w_in_pkt & r_start;
  assign r0_ack     = w_in_pkt & ~r_g & hs_ack;
  assign r1_ack     = w_in_pkt & r_g & hs_ack;
  assign hs_clk_req = !(r_state inside {S_OFF, S_CLK_DOWN});
  assign busy       = r_state != S_OFF;
  assign err        = r_err;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_OFF;
      r_g     <= 1'b1;
      r_start <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_next;
      r_g     <= w_g;
      r_start <= w_start;
      r_err   <= w_err;
      r_cnt   <= w_cnt;
    end
  always_comb begin
    w_next  = r_state;
    w_g     = r_g;
    w_start = r_start;
    w_err   = r_err;
    w_cnt   = r_cnt;
    case (r_state)
      S_OFF:      if (w_any) w_next = S_CLK_UP;
      S_CLK_UP:   if (hs_clk_rdy) w_next = S_ARB;
      S_ARB:
        if (w_any) begin
          w_next  = S_PKT;
          w_g     = w_pick;
          w_start = 1'b1;
        end else begin
          w_next = S_HOLD;
          w_cnt  = IDLE_LD;
        end
      // an ack with no valid byte is an underflow; only a real last byte ends the packet
      S_PKT:
        if (hs_ack) begin
          w_start = 1'b0;
          w_err   = r_err | ~w_gv;
          if (hs_last) begin
            w_next = S_GAP;
            w_cnt  = GAP_LD;
          end
        end
      S_GAP:
        if (r_cnt == 8'd0) w_next = S_ARB;
        else w_cnt = r_cnt - 8'd1;
      S_HOLD:
        if (w_any) w_next = S_ARB;
        else if (r_cnt == 8'd0) w_next = S_CLK_DOWN;
        else w_cnt = r_cnt - 8'd1;
      S_CLK_DOWN: if (!hs_clk_rdy) w_next = S_OFF;
      default:    w_next = S_OFF;
    endcase
  end
endmodule

// File: tb/tb_nano_dsi_sched.sv
// tb_nano_dsi_sched: requester/lane models with a byte scoreboard, an arbitration
// table and hand sequences for hold, clock-down, underflow and async reset.
module tb_nano_dsi_sched;
  localparam int GAP = 2;
  localparam int IDLE_TO = 64;
  typedef struct packed {logic hole; logic last; logic [7:0] d;} byte_t;
  typedef struct packed {logic [7:0] d; logic last; logic start; logic src;} exp_t;
  typedef struct {logic v0; logic v1; logic exp;} arb_row_t;

  logic clk = 1'b0, rst_n;
  logic r0_valid, r1_valid, r0_last, r1_last, r0_ack, r1_ack;
  logic [7:0] r0_data, r1_data, hs_data;
  logic hs_clk_req, hs_clk_rdy, hs_start, hs_last, hs_ack, busy, err;

  byte_t q0[$], q1[$];
  exp_t sb[$];
  int starts[$];
  arb_row_t rows[9];
  int cyc, n_chk, n_fail, up_dly, dn_dly, lane_cnt;
  int t_req_rise, t_req_fall, t_rdy_rise, t_rdy_fall, t_busy_fall, t_start, t_last_ack;
  int req_drops, n_ack0, n_ack1, t_push, rd, f, c;
  logic p_req, p_rdy, p_busy, p_start;
  logic [7:0] e_d;

  nano_dsi_sched #(.GAP(GAP), .IDLE_TO(IDLE_TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_data(r0_data), .r0_last(r0_last), .r0_ack(r0_ack),
    .r1_valid(r1_valid), .r1_data(r1_data), .r1_last(r1_last), .r1_ack(r1_ack),
    .hs_clk_req(hs_clk_req), .hs_clk_rdy(hs_clk_rdy), .hs_start(hs_start),
    .hs_data(hs_data), .hs_last(hs_last), .hs_ack(hs_ack), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, a, e);
    end
  endtask

  task automatic drive();
    r0_valid = q0.size() > 0 && !q0[0].hole;
    r0_data  = q0.size() > 0 ? q0[0].d : 8'h00;
    r0_last  = q0.size() > 0 && q0[0].last;
    r1_valid = q1.size() > 0 && !q1[0].hole;
    r1_data  = q1.size() > 0 ? q1[0].d : 8'h00;
    r1_last  = q1.size() > 0 && q1[0].last;
  endtask

  task automatic add(input logic src, input logic hole, input logic last, input logic [7:0] d);
    byte_t b;
    b = '{hole: hole, last: last, d: d};
    if (src) q1.push_back(b);
    else q0.push_back(b);
  endtask

  task automatic pkt(input logic src, input logic [7:0] base, input int len);
    for (int i = 0; i < len; i++) begin
      add(src, 1'b0, i == len - 1, 8'(base + 8'(i)));
      sb.push_back('{d: 8'(base + 8'(i)), last: i == len - 1, start: i == 0, src: src});
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (hs_clk_req && !p_req) t_req_rise = cyc;
    if (!hs_clk_req && p_req) begin t_req_fall = cyc; req_drops++; end
    if (hs_clk_rdy && !p_rdy) t_rdy_rise = cyc;
    if (!hs_clk_rdy && p_rdy) t_rdy_fall = cyc;
    if (!busy && p_busy) t_busy_fall = cyc;
    if (hs_start && !p_start) begin t_start = cyc; starts.push_back(cyc); end
    if (r0_ack || r1_ack) begin
      if (r0_ack) n_ack0++;
      if (r1_ack) n_ack1++;
      if (hs_last) t_last_ack = cyc;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected_ack at cycle %0d: got data %0h ack0 %0b ack1 %0b, expected no ack", cyc, hs_data, r0_ack, r1_ack);
      end else begin
        e = sb.pop_front();
        chk("sb_byte{data,last,start,ack1,ack0}", {20'd0, hs_data, hs_last, hs_start, r1_ack, r0_ack},
            {20'd0, e.d, e.last, e.start, e.src, ~e.src});
      end
    end
    p_req = hs_clk_req;
    p_rdy = hs_clk_rdy;
    p_busy = busy;
    p_start = hs_start;
  endtask

  // one clock: observe, let the edge pass, then update requester and lane models
  task automatic step();
    logic a0, a1, req, st, lst;
    #1;
    monitor();
    a0 = r0_ack; a1 = r1_ack; req = hs_clk_req; st = hs_start; lst = hs_last;
    @(posedge clk);
    #1;
    cyc++;
    if (a0 && q0.size() > 0) q0.delete(0);
    if (a1 && q1.size() > 0) q1.delete(0);
    hs_ack = st | ((a0 | a1) & ~lst);
    if (req != hs_clk_rdy) begin
      lane_cnt++;
      if (lane_cnt >= (req ? up_dly : dn_dly)) begin
        hs_clk_rdy = req;
        lane_cnt = 0;
      end
    end else lane_cnt = 0;
    drive();
    @(negedge clk);
  endtask

  task automatic run_sb(input int bound, input string nm);
    for (int n = 0; n < bound && sb.size() > 0; n++) step();
    chk({nm, "_pending_bytes"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic wait_idle(input int bound, input string nm);
    for (int n = 0; n < bound && busy; n++) step();
    chk({nm, "_busy"}, 32'(busy), 0);
  endtask

  task automatic idle_until(input int target);
    while (cyc < target) step();
  endtask

  initial begin
    rows = '{'{1'b1, 1'b1, 1'b0}, '{1'b1, 1'b1, 1'b1}, '{1'b1, 1'b0, 1'b0},
             '{1'b0, 1'b1, 1'b1}, '{1'b1, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b1},
             '{1'b1, 1'b1, 1'b0}, '{1'b1, 1'b1, 1'b1}, '{1'b1, 1'b0, 1'b0}};
    n_chk = 0; n_fail = 0; cyc = 0; lane_cnt = 0; up_dly = 5; dn_dly = 3;
    req_drops = 0; n_ack0 = 0; n_ack1 = 0;
    p_req = 0; p_rdy = 0; p_busy = 0; p_start = 0;
    hs_clk_rdy = 1'b0; hs_ack = 1'b0;
    rst_n = 1'b1;
    drive();
    #1 rst_n = 1'b0;
    @(negedge clk);
    step();
    step();
    chk("reset_outputs", 32'({hs_clk_req, hs_start, hs_last, hs_data, r0_ack, r1_ack, busy, err}), 0);
    rst_n = 1'b1;

    // contention: both requesters always have a 2-byte packet queued
    starts.delete();
    pkt(1'b0, 8'h01, 2); pkt(1'b1, 8'h03, 2); pkt(1'b0, 8'h05, 2); pkt(1'b1, 8'h07, 2);
    drive();
    run_sb(300, "contention");
    chk("cont_start_count", starts.size(), 4);
    for (int i = 1; i < starts.size(); i++) chk("cont_start_spacing", starts[i] - starts[i-1], 2 + GAP + 2);

    // arbitration table: each row makes the listed requesters valid and expects one grant
    for (int i = 0; i < 9; i++) begin
      if (rows[i].v0 && q0.size() == 0) add(1'b0, 1'b0, 1'b1, 8'(8'h40 + 8'(i)));
      if (rows[i].v1 && q1.size() == 0) add(1'b1, 1'b0, 1'b1, 8'(8'h80 + 8'(i)));
      e_d = rows[i].exp ? q1[0].d : q0[0].d;
      sb.push_back('{d: e_d, last: 1'b1, start: 1'b1, src: rows[i].exp});
      drive();
      run_sb(60, "arb_row");
    end

    // request while HOLD count is 3
    c = t_last_ack;
    idle_until(c + GAP + 2 + IDLE_TO - 4);
    pkt(1'b1, 8'h90, 1);
    drive();
    t_push = cyc; rd = req_drops;
    run_sb(50, "hold_req");
    chk("hold_warm_start", t_start - t_push, 2);
    chk("hold_req_kept", req_drops - rd, 0);

    // request landing on the expiry cycle
    c = t_last_ack;
    idle_until(c + GAP + 2 + IDLE_TO - 1);
    pkt(1'b1, 8'h91, 1);
    drive();
    t_push = cyc; rd = req_drops;
    run_sb(50, "expiry_req");
    chk("expiry_warm_start", t_start - t_push, 2);
    chk("expiry_req_kept", req_drops - rd, 0);

    // request during CLK_DOWN with rdy held high for 10 cycles
    dn_dly = 10;
    for (int n = 0; n < 200 && hs_clk_req; n++) step();
    chk("cdown_req_fell", 32'(hs_clk_req), 0);
    f = cyc;
    pkt(1'b0, 8'h70, 1);
    drive();
    for (int n = 0; n < 50 && busy; n++) step();
    chk("cdown_off_cycle", cyc - f, 11);
    step();
    chk("cdown_req_back", 32'(hs_clk_req), 1);
    run_sb(100, "cdown_pkt");
    dn_dly = 3;

    // single cold packet
    wait_idle(200, "pre_cold");
    step();
    n_ack0 = 0; n_ack1 = 0;
    pkt(1'b0, 8'h10, 4);
    drive();
    t_push = cyc;
    run_sb(100, "cold_pkt");
    wait_idle(200, "cold_release");
    step();
    chk("cold_req_rise", t_req_rise - t_push, 1);
    chk("cold_start_after_rdy", t_start - t_rdy_rise, 2);
    chk("cold_r0_acks", n_ack0, 4);
    chk("cold_r1_acks", n_ack1, 0);
    chk("clk_release_delay", t_req_fall - t_last_ack, GAP + 2 + IDLE_TO);
    chk("busy_after_rdy_fall", t_busy_fall - t_rdy_fall, 1);
    chk("cold_busy_stays_low", 32'(busy), 0);

    // underflow: one acked cycle with r0_valid low
    chk("err_before_underflow", 32'(err), 0);
    add(1'b0, 1'b0, 1'b0, 8'h20); add(1'b0, 1'b0, 1'b0, 8'h21);
    add(1'b0, 1'b1, 1'b1, 8'hEE); add(1'b0, 1'b0, 1'b1, 8'h22);
    sb.push_back('{8'h20, 1'b0, 1'b1, 1'b0}); sb.push_back('{8'h21, 1'b0, 1'b0, 1'b0});
    sb.push_back('{8'h00, 1'b0, 1'b0, 1'b0}); sb.push_back('{8'h22, 1'b1, 1'b0, 1'b0});
    drive();
    run_sb(150, "underflow");
    chk("err_set", 32'(err), 1);
    for (int n = 0; n < 5; n++) step();
    chk("err_sticky", 32'(err), 1);

    // async reset in the middle of an r0 packet
    pkt(1'b0, 8'h30, 8);
    drive();
    for (int n = 0; n < 100 && !hs_start; n++) step();
    chk("rst_pkt_started", 32'(hs_start), 1);
    step();
    step();
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", 32'({hs_clk_req, hs_start, hs_last, hs_data, r0_ack, r1_ack, busy, err}), 0);
    q0.delete(); q1.delete(); sb.delete();
    hs_clk_rdy = 1'b0; hs_ack = 1'b0; lane_cnt = 0;
    drive();
    step();
    step();
    rst_n = 1'b1;
    pkt(1'b0, 8'h50, 1); pkt(1'b1, 8'h60, 1);
    drive();
    run_sb(200, "post_reset_contention");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
